// File: rtl/ptw_dcache_rsp_port.sv
// ptw_dcache_rsp_port: dcache-side responder for the PTW page-table read port.
// Serves one read at a time: index grant, tag phase, one 64b backing read, response.
// Optional feature macro: PTW_RSP_PARITY_EN (data_ruser_o = even parity of read data).
module ptw_dcache_rsp_port #(
    parameter int unsigned INDEX_W   = 12,
    parameter int unsigned TAG_W     = 44,
    parameter int unsigned ID_W      = 3,
    parameter int unsigned GNT_DELAY = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       data_req_i,
    input  logic                       data_we_i,
    input  logic [INDEX_W-1:0]         address_index_i,
    input  logic [ID_W-1:0]            data_id_i,
    output logic                       data_gnt_o,
    input  logic                       tag_valid_i,
    input  logic [TAG_W-1:0]           address_tag_i,
    input  logic                       kill_req_i,
    output logic                       data_rvalid_o,
    output logic [ID_W-1:0]            data_rid_o,
    output logic [63:0]                data_rdata_o,
    output logic                       data_ruser_o,
    output logic                       mem_req_o,
    output logic [TAG_W+INDEX_W-4:0]   mem_addr_o,
    input  logic                       mem_gnt_i,
    input  logic                       mem_rvalid_i,
    input  logic [63:0]                mem_rdata_i,
    output logic                       busy_o,
    output logic                       protocol_err_o
);

    localparam int unsigned CNT_W = (GNT_DELAY < 1) ? 1 : $clog2(GNT_DELAY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TAG,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_RESP,
        S_DRAIN
    } state_e;

    state_e             state;
    state_e             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [INDEX_W-1:0] index_q;
    logic [ID_W-1:0]    id_q;
    logic [TAG_W-1:0]   tag_q;
    logic               ruser_next;
    logic               unused_index_bits;

    // User bit computed from the raw backing word, captured together with it
`ifdef PTW_RSP_PARITY_EN
    assign ruser_next = ^mem_rdata_i;
`else
    assign ruser_next = 1'b0;
`endif

    // Backing memory is word addressed: drop the byte offset within the 64b word
    assign mem_addr_o        = {tag_q, index_q[INDEX_W-1:3]};
    assign unused_index_bits = ^index_q[2:0];

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush aborts everything except an already captured response
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (data_gnt_o) state_next = S_TAG;
            end
            S_TAG: begin
                if (flush_i || kill_req_i || !tag_valid_i) state_next = S_IDLE;
                else                                       state_next = S_MEM_REQ;
            end
            S_MEM_REQ: begin
                if (flush_i)        state_next = mem_gnt_i ? S_DRAIN : S_IDLE;
                else if (mem_gnt_i) state_next = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                if (mem_rvalid_i) state_next = flush_i ? S_IDLE : S_RESP;
                else if (flush_i) state_next = S_DRAIN;
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            S_DRAIN: begin
                if (mem_rvalid_i) state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State-decoded handshake outputs; grant is combinational on the request
    always_comb begin
        data_gnt_o    = 1'b0;
        mem_req_o     = 1'b0;
        data_rvalid_o = 1'b0;
        busy_o        = (state != S_IDLE);
        case (state)
            S_IDLE:    data_gnt_o    = data_req_i & ~flush_i & ~rst_i
                                     & (cnt == CNT_W'(GNT_DELAY));
            S_MEM_REQ: mem_req_o     = 1'b1;
            S_RESP:    data_rvalid_o = 1'b1;
            default:   data_gnt_o    = 1'b0;
        endcase
    end

    // Grant-delay counter, request/tag capture, response capture and sticky error
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt            <= '0;
            index_q        <= '0;
            id_q           <= '0;
            tag_q          <= '0;
            data_rdata_o   <= '0;
            data_rid_o     <= '0;
            data_ruser_o   <= 1'b0;
            protocol_err_o <= 1'b0;
        end else begin
            if (state == S_IDLE && data_req_i && !flush_i && !data_gnt_o) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end

            if (data_gnt_o) begin
                index_q <= address_index_i;
                id_q    <= data_id_i;
                if (data_we_i) protocol_err_o <= 1'b1;
            end

            if (state == S_TAG && !flush_i && !kill_req_i) begin
                if (tag_valid_i) tag_q          <= address_tag_i;
                else             protocol_err_o <= 1'b1;
            end

            if (state == S_MEM_WAIT && mem_rvalid_i && !flush_i) begin
                data_rdata_o <= mem_rdata_i;
                data_rid_o   <= id_q;
                data_ruser_o <= ruser_next;
            end
        end
    end

endmodule
